// File: rtl/fifo_mon_pkg.sv
// Shared types for the FIFO flag monitor.
// Holds check indices, monitor states and a priority helper.
package fifo_mon_pkg;

  localparam int NUM_CHECKS = 7;

  typedef enum logic [2:0] {
    CHK_FULL   = 3'd0,
    CHK_EMPTY  = 3'd1,
    CHK_AFULL  = 3'd2,
    CHK_AEMPTY = 3'd3,
    CHK_ACK    = 3'd4,
    CHK_OVF    = 3'd5,
    CHK_UDF    = 3'd6
  } chk_e;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    HALTED   = 2'd2
  } mon_state_e;

  function automatic logic [2:0] lowest_set(
    input logic [NUM_CHECKS-1:0] v
  );
    lowest_set = 3'd0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--)
      if (v[i]) lowest_set = 3'(i);
  endfunction

endpackage

// File: rtl/fifo_shadow_model.sv
// Occupancy model of a synchronous FIFO: accept logic, expected flags.
// Ports: clk, rst, wr_en, rd_en in; cnt and exp_* flags/responses out.
module fifo_shadow_model
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int AF_GAP = 1,
  parameter int AE_GAP = 1,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [CW-1:0] cnt,
  output logic          exp_full,
  output logic          exp_empty,
  output logic          exp_afull,
  output logic          exp_aempty,
  output logic          exp_ack,
  output logic          exp_ovf,
  output logic          exp_udf
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(DEPTH - AF_GAP);
  localparam logic [CW-1:0] AE_C   = CW'(AE_GAP);

  logic at_full;
  logic at_empty;
  logic wr_acc;
  logic rd_acc;

  assign at_full  = (cnt == FULL_C);
  assign at_empty = (cnt == '0);

  // At full a simultaneous read frees no slot for this cycle's write;
  // at empty the write's data is not yet readable.
  assign wr_acc = wr_en & ~at_full;
  assign rd_acc = rd_en & ~at_empty;

  assign exp_full   = at_full;
  assign exp_empty  = at_empty;
  assign exp_afull  = (cnt == AF_C);
  assign exp_aempty = (cnt == AE_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      exp_ack <= 1'b0;
      exp_ovf <= 1'b0;
      exp_udf <= 1'b0;
    end else begin
      cnt     <= cnt + CW'(wr_acc) - CW'(rd_acc);
      exp_ack <= wr_acc;
      exp_ovf <= wr_en & at_full;
      exp_udf <= rd_en & at_empty;
    end
  end

endmodule

// File: rtl/fifo_flag_monitor.sv
// Protocol monitor: compares FIFO flags/responses with a shadow model.
// Ports: mon_* observed inputs; err_* status, shadow_count, state out.
module fifo_flag_monitor
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int AF_GAP      = 1,
  parameter int AE_GAP      = 1,
  parameter int ERR_CNT_W   = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mon_en,
  input  logic                         err_clr,
  input  logic                         mon_wr_en,
  input  logic                         mon_rd_en,
  input  logic                         mon_full,
  input  logic                         mon_almostfull,
  input  logic                         mon_empty,
  input  logic                         mon_almostempty,
  input  logic                         mon_wr_ack,
  input  logic                         mon_overflow,
  input  logic                         mon_underflow,
  output logic [$clog2(DEPTH+1)-1:0]   shadow_count,
  output logic [NUM_CHECKS-1:0]        err_vec,
  output logic                         err_pulse,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic [2:0]                   first_err_id,
  output logic [$clog2(DEPTH+1)-1:0]   first_err_cnt,
  output logic [1:0]                   state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CHECKS-1:0] exp_v;
  logic [NUM_CHECKS-1:0] obs_v;
  logic [NUM_CHECKS-1:0] mism;
  logic                  err_now;
  logic [ERR_CNT_W-1:0]  cnt_base;
  logic [ERR_CNT_W-1:0]  cnt_nxt;
  logic [NUM_CHECKS-1:0] vec_nxt;
  logic                  load_first;
  mon_state_e            st;
  mon_state_e            st_nxt;

  fifo_shadow_model #(
    .DEPTH (DEPTH),
    .AF_GAP(AF_GAP),
    .AE_GAP(AE_GAP),
    .CW    (CW)
  ) u_model (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (mon_wr_en),
    .rd_en     (mon_rd_en),
    .cnt       (shadow_count),
    .exp_full  (exp_v[CHK_FULL]),
    .exp_empty (exp_v[CHK_EMPTY]),
    .exp_afull (exp_v[CHK_AFULL]),
    .exp_aempty(exp_v[CHK_AEMPTY]),
    .exp_ack   (exp_v[CHK_ACK]),
    .exp_ovf   (exp_v[CHK_OVF]),
    .exp_udf   (exp_v[CHK_UDF])
  );

  assign obs_v = {mon_underflow, mon_overflow, mon_wr_ack,
                  mon_almostempty, mon_almostfull,
                  mon_empty, mon_full};

  assign mism    = obs_v ^ exp_v;
  assign err_now = (|mism) && (st == ARMED);
  assign state   = st;

  // A clear coinciding with a new error restarts history from that error.
  always_comb begin
    cnt_base = err_clr ? '0 : err_count;
    cnt_nxt  = cnt_base;
    if (err_now && cnt_base != CNT_MAX)
      cnt_nxt = cnt_base + ERR_CNT_W'(1);
    vec_nxt = err_clr ? '0 : err_vec;
    if (err_now)
      vec_nxt = vec_nxt | mism;
    load_first = err_now && (cnt_base == '0);
  end

  always_comb begin
    st_nxt = st;
    case (st)
      DISARMED: if (mon_en) st_nxt = ARMED;
      ARMED: begin
        if (err_now && STOP_ON_ERR != 0) st_nxt = HALTED;
        else if (!mon_en)                st_nxt = DISARMED;
      end
      HALTED:   if (err_clr) st_nxt = ARMED;
      default:  st_nxt = DISARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= DISARMED;
      err_vec       <= '0;
      err_pulse     <= 1'b0;
      err_count     <= '0;
      first_err_id  <= 3'd0;
      first_err_cnt <= '0;
    end else begin
      st        <= st_nxt;
      err_vec   <= vec_nxt;
      err_pulse <= err_now;
      err_count <= cnt_nxt;
      if (load_first) begin
        first_err_id  <= lowest_set(mism);
        first_err_cnt <= shadow_count;
      end
    end
  end

endmodule

// File: tb/tb_fifo_flag_monitor.sv
// Directed bench for fifo_flag_monitor: correct FIFO model plus
// per-flag fault mask, three monitor configurations in parallel.
module tb_fifo_flag_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic wr  = 1'b0;
  logic rd  = 1'b0;
  logic [6:0] fmask = '0;

  always #5 clk = ~clk;

  // Reference FIFO (DEPTH 8, gaps 1) whose outputs can be corrupted.
  logic [3:0] fcnt;
  logic f_ack, f_ovf, f_udf;
  logic o_full, o_empty, o_af, o_ae, o_ack, o_ovf, o_udf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      f_ack <= 1'b0;
      f_ovf <= 1'b0;
      f_udf <= 1'b0;
    end else begin
      f_ack <= wr && fcnt < 4'd8;
      f_ovf <= wr && fcnt == 4'd8;
      f_udf <= rd && fcnt == 4'd0;
      fcnt  <= fcnt + 4'(wr && fcnt < 4'd8)
                    - 4'(rd && fcnt > 4'd0);
    end
  end

  assign o_full  = (fcnt == 4'd8) ^ fmask[0];
  assign o_empty = (fcnt == 4'd0) ^ fmask[1];
  assign o_af    = (fcnt == 4'd7) ^ fmask[2];
  assign o_ae    = (fcnt == 4'd1) ^ fmask[3];
  assign o_ack   = f_ack ^ fmask[4];
  assign o_ovf   = f_ovf ^ fmask[5];
  assign o_udf   = f_udf ^ fmask[6];

  logic [3:0] d_sc, h_sc, s_sc;
  logic [6:0] d_ev, h_ev, s_ev;
  logic       d_ep, h_ep, s_ep;
  logic [7:0] d_ec, h_ec;
  logic [1:0] s_ec;
  logic [2:0] d_fi, h_fi, s_fi;
  logic [3:0] d_fc, h_fc, s_fc;
  logic [1:0] d_st, h_st, s_st;

  fifo_flag_monitor u_def (
    .clk(clk), .rst(rst), .mon_en(en), .err_clr(clr),
    .mon_wr_en(wr), .mon_rd_en(rd),
    .mon_full(o_full), .mon_almostfull(o_af),
    .mon_empty(o_empty), .mon_almostempty(o_ae),
    .mon_wr_ack(o_ack), .mon_overflow(o_ovf),
    .mon_underflow(o_udf),
    .shadow_count(d_sc), .err_vec(d_ev), .err_pulse(d_ep),
    .err_count(d_ec), .first_err_id(d_fi),
    .first_err_cnt(d_fc), .state(d_st)
  );

  fifo_flag_monitor #(.STOP_ON_ERR(1)) u_halt (
    .clk(clk), .rst(rst), .mon_en(en), .err_clr(clr),
    .mon_wr_en(wr), .mon_rd_en(rd),
    .mon_full(o_full), .mon_almostfull(o_af),
    .mon_empty(o_empty), .mon_almostempty(o_ae),
    .mon_wr_ack(o_ack), .mon_overflow(o_ovf),
    .mon_underflow(o_udf),
    .shadow_count(h_sc), .err_vec(h_ev), .err_pulse(h_ep),
    .err_count(h_ec), .first_err_id(h_fi),
    .first_err_cnt(h_fc), .state(h_st)
  );

  fifo_flag_monitor #(.ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .mon_en(en), .err_clr(clr),
    .mon_wr_en(wr), .mon_rd_en(rd),
    .mon_full(o_full), .mon_almostfull(o_af),
    .mon_empty(o_empty), .mon_almostempty(o_ae),
    .mon_wr_ack(o_ack), .mon_overflow(o_ovf),
    .mon_underflow(o_udf),
    .shadow_count(s_sc), .err_vec(s_ev), .err_pulse(s_ep),
    .err_count(s_ec), .first_err_id(s_fi),
    .first_err_cnt(s_fc), .state(s_st)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic r,
                      input logic c, input logic [6:0] m);
    wr    = w;
    rd    = r;
    clr   = c;
    fmask = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    clr   = 1'b0;
    fmask = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    step(0, 0, 0, '0);
  endtask

  initial begin
    // Reset values
    @(posedge clk);
    #1;
    chk("rst_sc", d_sc, 0);
    chk("rst_ev", d_ev, 0);
    chk("rst_ep", d_ep, 0);
    chk("rst_ec", d_ec, 0);
    chk("rst_fi", d_fi, 0);
    chk("rst_fc", d_fc, 0);
    chk("rst_st", d_st, 0);
    do_reset();
    chk("arm_st", d_st, 1);

    // Fill / drain with overflow and underflow
    for (int i = 0; i < 9; i++) step(1, 0, 0, '0);
    chk("fill_sc", d_sc, 8);
    for (int i = 0; i < 9; i++) step(0, 1, 0, '0);
    chk("drain_sc", d_sc, 0);
    step(0, 0, 0, '0);
    chk("fd_ev", d_ev, 0);
    chk("fd_ec", d_ec, 0);
    chk("fd_ep", d_ep, 0);

    // Almost-full fault at cnt 7
    for (int i = 0; i < 7; i++) step(1, 0, 0, '0);
    chk("af_sc", d_sc, 7);
    step(0, 0, 0, 7'b0000100);
    chk("af_ep", d_ep, 1);
    chk("af_ev", d_ev, 7'b0000100);
    chk("af_fi", d_fi, 2);
    chk("af_fc", d_fc, 7);
    chk("af_ec", d_ec, 1);
    step(0, 0, 0, '0);
    chk("af_ep_low", d_ep, 0);

    // Simultaneous requests at boundaries
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    chk("full_wr_rd_sc", d_sc, 7);
    step(0, 0, 0, '0);
    chk("full_ovf_ok", d_ev, 0);
    step(1, 0, 0, '0);
    step(1, 1, 0, '0);
    step(0, 0, 0, 7'b0100000);
    chk("ovf_miss_ev", d_ev, 7'b0100000);
    chk("ovf_miss_fi", d_fi, 5);
    chk("ovf_miss_fc", d_fc, 7);
    for (int i = 0; i < 7; i++) step(0, 1, 0, '0);
    chk("drain0_sc", d_sc, 0);
    step(1, 1, 0, '0);
    chk("empty_wr_rd_sc", d_sc, 1);
    step(0, 0, 0, '0);
    chk("empty_udf_ok", d_ec, 1);
    step(0, 1, 0, '0);
    step(1, 1, 0, '0);
    step(0, 0, 0, 7'b1000000);
    chk("udf_miss_ev", d_ev, 7'b1100000);
    chk("udf_miss_ec", d_ec, 2);

    // Halt and clear
    do_reset();
    step(1, 0, 0, '0);
    step(0, 0, 0, 7'b0010000);
    chk("halt_st", h_st, 2);
    chk("halt_ev4", 32'(h_ev[4]), 1);
    chk("halt_fi", h_fi, 4);
    chk("halt_fc", h_fc, 1);
    step(0, 0, 0, 7'b0000001);
    step(0, 0, 0, 7'b0000010);
    chk("halt_ec", h_ec, 1);
    chk("nohalt_ec", d_ec, 3);
    step(0, 0, 0, '0);
    chk("halt_hold_st", h_st, 2);
    step(0, 0, 1, '0);
    chk("clr_st", h_st, 1);
    chk("clr_ev", h_ev, 0);
    chk("clr_ec", h_ec, 0);

    // Saturation and clear race
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 7'b0000001);
    chk("sat_ec", s_ec, 3);
    chk("wide_ec", d_ec, 5);
    step(0, 0, 1, 7'b0001000);
    chk("race_ec", s_ec, 1);
    chk("race_ev", s_ev, 7'b0001000);
    chk("race_fi", s_fi, 3);
    chk("race_wide_ec", d_ec, 1);

    // Asynchronous reset mid-fill
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0);
    chk("pre_rst_sc", d_sc, 5);
    step(0, 0, 0, 7'b0000001);
    chk("pre_rst_ep", d_ep, 1);
    rst = 1'b1;
    #1;
    chk("arst_sc", d_sc, 0);
    chk("arst_ev", d_ev, 0);
    chk("arst_ep", d_ep, 0);
    chk("arst_ec", d_ec, 0);
    chk("arst_fi", d_fi, 0);
    chk("arst_fc", d_fc, 0);
    chk("arst_st", d_st, 0);
    fmask = '0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("post_rst_st", d_st, 1);
    chk("post_rst_ec", d_ec, 0);
    chk("post_rst_ev", d_ev, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_flag_monitor.md
# fifo_flag_monitor

Synthesizable, parametrised protocol monitor for the team's synchronous FIFOs. It observes a FIFO's write/read requests and status flags and keeps its own occupancy model. Each cycle it checks full, empty, almost-full, almost-empty, write-ack, overflow and underflow against that model, and reports sticky per-check errors, a saturating error count and a first-error capture. It sits beside the FIFO in both the design and the bench, and generalises the existing assertion checks to any depth and to configurable almost-thresholds.

## Interface
- DEPTH, 8: FIFO depth being monitored (≥ 2).
- AF_GAP, 1: almostfull expected when count == DEPTH-AF_GAP (1 ≤ AF_GAP < DEPTH).
- AE_GAP, 1: almostempty expected when count == AE_GAP (1 ≤ AE_GAP < DEPTH).
- ERR_CNT_W, 8: width of the error counter.
- STOP_ON_ERR, 0: 1 = enter HALTED on the first error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mon_en  in  1  arms checking.
- err_clr  in  1  clears errors and leaves HALTED.
- mon_wr_en, mon_rd_en  in  1 each  FIFO requests.
- mon_full, mon_almostfull, mon_empty, mon_almostempty  in  1 each  FIFO combinational flags.
- mon_wr_ack, mon_overflow, mon_underflow  in  1 each  FIFO registered responses.
- shadow_count  out  $clog2(DEPTH+1)  model occupancy.
- err_vec  out  7  sticky per-check error bits; index order is full, empty, afull, aempty, ack, ovf, udf.
- err_pulse  out  1  one-cycle pulse per erroring cycle.
- err_count  out  ERR_CNT_W  saturating count of erroring cycles.
- first_err_id  out  3  lowest failing index at the first error.
- first_err_cnt  out  $clog2(DEPTH+1)  shadow_count at the first error.
- state  out  2  DISARMED=0, ARMED=1, HALTED=2.

## Operation
- Model update:
  - A write is accepted iff mon_wr_en and cnt < DEPTH.
  - A read is accepted iff mon_rd_en and cnt > 0.
  - Both use the pre-update cnt.
  - Next cnt = cnt + wr_acc − rd_acc.
- Simultaneous requests:
  - At full, the read is accepted and the write is rejected, so overflow is expected.
  - At empty, the write is accepted and the read is rejected, so underflow is expected.
- Expected combinational flags, all from current cnt:
  - full = (cnt == DEPTH).
  - empty = (cnt == 0).
  - afull = (cnt == DEPTH-AF_GAP).
  - aempty = (cnt == AE_GAP).
- Expected registered responses, all registered from the previous cycle:
  - ack = wr_acc.
  - ovf = mon_wr_en && cnt == DEPTH.
  - udf = mon_rd_en && cnt == 0.
- Check: a bit mismatches when observed ≠ expected. The cycle errs if any bit mismatches and state == ARMED.
- The shadow model tracks in every state. Only reporting is gated.
- FSM:
  - DISARMED → ARMED when mon_en = 1.
  - ARMED → DISARMED when mon_en = 0.
  - ARMED → HALTED on an erroring cycle when STOP_ON_ERR = 1.
  - HALTED → ARMED on err_clr.
  - HALTED ignores mon_en.
- err_vec |= mismatch bits on an erroring cycle.
- err_count increments by 1 per erroring cycle and saturates at all-ones.
- first_err_id and first_err_cnt load only when err_count == 0 and the cycle errs.
- err_clr zeroes err_vec and err_count. If a new error occurs in the same cycle, the new error wins: err_vec = new bits, err_count = 1, and first_err is reloaded.

## Timing
- Reset values: shadow_count = 0, err_vec = 0, err_pulse = 0, err_count = 0, first_err_id = 0, first_err_cnt = 0, state = DISARMED, expected-registered flags = 0.
- Reset mid-operation clears everything immediately (asynchronous). The first compare after release is against cnt = 0.
- Comparison happens in cycle N. err_pulse, err_vec, err_count and state update at the edge ending cycle N, so they are visible in N+1. That is one cycle of latency.
- Responses: mon_wr_ack, mon_overflow and mon_underflow in cycle N+1 are compared with the requests and cnt of cycle N.
- shadow_count follows the FIFO's count with no lag. It changes on the same edge as the FIFO's internal counter.

## Structure
- fifo_mon_pkg holds:
  - NUM_CHECKS = 7.
  - The check-index enum: CHK_FULL..CHK_UDF.
  - mon_state_e: DISARMED, ARMED, HALTED.
- Sub-module fifo_shadow_model, parametrised by DEPTH, AF_GAP and AE_GAP:
  - Holds cnt and the accept logic.
  - Outputs the expected combinational flags and the registered ack/ovf/udf.
- The top level holds the compare, the FSM, the error registers and the first-error capture.

## Test plan
All scenarios use DEPTH = 8, AF_GAP = 1, AE_GAP = 1.

- Fill/drain: with a correct FIFO and mon_en = 1, perform 9 writes then 9 reads.
  - Required: shadow_count goes 0→8→0.
  - Required: the 9th write is followed by an expected overflow and the 9th read by an expected underflow.
  - Required: err_vec = 0 and err_count = 0 throughout.
- Almost-flag fault: force mon_almostfull = 0 when cnt = 7.
  - Required: err_pulse next cycle, err_vec = 7'b0000100, first_err_id = 2, first_err_cnt = 7.
- Simultaneous requests at boundaries:
  - At cnt = 8, wr+rd → cnt = 7, with mon_overflow = 1 expected next cycle.
  - At cnt = 0, wr+rd → cnt = 1, with mon_underflow = 1 expected next cycle.
  - A FIFO that omits either response sets the ovf or udf bit.
- Halt and clear: with STOP_ON_ERR = 1, inject a missing wr_ack.
  - Required: state = HALTED and err_vec[4] = 1.
  - Required: further faults leave err_count = 1.
  - Required: err_clr → state ARMED, err_vec = 0.
- Saturation and clear race: with ERR_CNT_W = 2, inject 5 consecutive faults.
  - Required: err_count = 3.
  - Required: err_clr in the same cycle as a fault gives err_count = 1.
- Async reset: assert rst mid-fill at cnt = 5.
  - Required: all outputs reset immediately and state = DISARMED.
  - Required: after release with an empty FIFO, no error.
